// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and sizing helpers for the multicycle ALU
// Contents: op_t opcode enum, state_t FSM enum, default width and counter-width helpers.
package alu_pkg;

    typedef enum logic [2:0] {
        OP_NOT = 3'b000,
        OP_AND = 3'b001,
        OP_OR  = 3'b010,
        OP_ADD = 3'b011,
        OP_SUB = 3'b100,
        OP_MUL = 3'b101,
        OP_DIV = 3'b110,
        OP_ILL = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

    // Iteration counter width for a given operand width; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// rtl/alu_iter_muldiv.sv - shared iterative shift-add multiplier / restoring divider
// Ports: clk, reset (sync, active-high), start (load operands), is_div (select DIV),
//        a/b (operands), done (high on the final iteration), result (value produced by
//        the final iteration, valid while done is high).
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // acc: product accumulator (MUL) or partial remainder (DIV).
    // sr:  multiplier shifting right (MUL) or dividend/quotient shifting left (DIV).
    // opnd: multiplicand shifting left (MUL) or fixed divisor (DIV).
    logic             busy;
    logic             div_mode;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] opnd;

    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] sr_nx;
    logic [WIDTH-1:0] opnd_nx;
    logic [WIDTH:0]   trial;
    logic [WIDTH:0]   diff;

    always_comb begin
        trial   = {acc, sr[WIDTH-1]};
        diff    = trial - {1'b0, opnd};
        acc_nx  = acc;
        sr_nx   = sr;
        opnd_nx = opnd;
        if (div_mode) begin
            // The partial remainder is always below the divisor, so diff[WIDTH]
            // is exactly the borrow of the trial subtraction.
            if (!diff[WIDTH]) begin
                acc_nx = diff[WIDTH-1:0];
                sr_nx  = {sr[WIDTH-2:0], 1'b1};
            end else begin
                acc_nx = trial[WIDTH-1:0];
                sr_nx  = {sr[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (sr[0]) begin
                acc_nx = acc + opnd;
            end
            sr_nx   = sr >> 1;
            opnd_nx = opnd << 1;
        end
    end

    assign done   = busy && (cnt == LAST);
    assign result = div_mode ? sr_nx : acc_nx;

    always_ff @(posedge clk) begin
        if (reset) begin
            busy     <= 1'b0;
            div_mode <= 1'b0;
            cnt      <= '0;
            acc      <= '0;
            sr       <= '0;
            opnd     <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            div_mode <= is_div;
            cnt      <= '0;
            acc      <= '0;
            sr       <= is_div ? a : b;
            opnd     <= is_div ? b : a;
        end else if (busy) begin
            acc  <= acc_nx;
            sr   <= sr_nx;
            opnd <= opnd_nx;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - handshaked ALU: single-cycle logic/add/sub, iterative mul/div
// Ports: Clock, Reset (sync, active-high); issue side InValid/InReady/A/B/Operation;
//        result side OutValid/OutReady/Output with Zero, Carry, Error flags.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Operation,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Output,
    output logic             Zero,
    output logic             Carry,
    output logic             Error
);

    state_t           state;
    op_t              op;
    logic             accept;
    logic             b_zero;
    logic             iter_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_result;
    logic             sc_carry;
    logic             sc_error;
    logic             iter_done;
    logic [WIDTH-1:0] iter_result;

    assign op      = op_t'(Operation);
    assign accept  = InValid && InReady;
    assign b_zero  = (B == '0);
    assign iter_op = (op == OP_MUL) || ((op == OP_DIV) && !b_zero);
    assign sum     = {1'b0, A} + {1'b0, B};

    // Single-cycle result; DIV only reaches this path with B == 0.
    always_comb begin
        sc_result = '0;
        sc_carry  = 1'b0;
        sc_error  = 1'b0;
        case (op)
            OP_NOT: sc_result = ~A;
            OP_AND: sc_result = A & B;
            OP_OR:  sc_result = A | B;
            OP_ADD: begin
                sc_result = sum[WIDTH-1:0];
                sc_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                sc_result = A - B;
                sc_carry  = (A < B);
            end
            OP_DIV: begin
                sc_result = '1;
                sc_error  = 1'b1;
            end
            OP_ILL: sc_error = 1'b1;
            default: sc_result = '0;
        endcase
    end

    alu_iter_muldiv #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk   (Clock),
        .reset (Reset),
        .start (accept && iter_op),
        .is_div(op == OP_DIV),
        .a     (A),
        .b     (B),
        .done  (iter_done),
        .result(iter_result)
    );

    // InReady is registered from state, so it rises one cycle after IDLE is entered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            InReady  <= 1'b0;
            OutValid <= 1'b0;
            Output   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Error    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    InReady <= 1'b1;
                    if (accept) begin
                        InReady <= 1'b0;
                        if (iter_op) begin
                            state <= BUSY;
                        end else begin
                            state    <= DONE;
                            OutValid <= 1'b1;
                            Output   <= sc_result;
                            Zero     <= (sc_result == '0);
                            Carry    <= sc_carry;
                            Error    <= sc_error;
                        end
                    end
                end
                BUSY: begin
                    InReady <= 1'b0;
                    if (iter_done) begin
                        state    <= DONE;
                        OutValid <= 1'b1;
                        Output   <= iter_result;
                        Zero     <= (iter_result == '0);
                        Carry    <= 1'b0;
                        Error    <= 1'b0;
                    end
                end
                DONE: begin
                    InReady <= 1'b0;
                    if (OutReady) begin
                        state    <= IDLE;
                        OutValid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    InReady  <= 1'b0;
                    OutValid <= 1'b0;
                end
            endcase
        end
    end

endmodule
